// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA-3 rate-block padder.
// Rate is 576 bits (18 x 32-bit words), i.e. the SHA3-512 rate.
package sha3_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned RATE_WORDS = 18;
  localparam int unsigned RATE_W     = 576;

  localparam logic [7:0] PAD_START = 8'h01;
  localparam logic [7:0] PAD_END   = 8'h80;

  localparam logic [4:0] LAST_CNT = 5'(RATE_WORDS);

  typedef enum logic [1:0] {
    ACCEPT,
    PAD,
    FULL
  } state_e;

endpackage

// File: rtl/sha3_pad_word.sv
// Builds the final message word: keeps the valid leading bytes and places the
// 0x01 domain/pad byte directly after them, zeroing the rest.
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  logic [1:0]        byte_num,
  output logic [WORD_W-1:0] out
);

  always_comb begin
    out = '0;
    unique case (byte_num)
      2'd0: out = {PAD_START, 24'h00_0000};
      2'd1: out = {in[31:24], PAD_START, 16'h0000};
      2'd2: out = {in[31:16], PAD_START, 8'h00};
      2'd3: out = {in[31:8], PAD_START};
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/sha3_padder.sv
// Collects 32-bit message words into 576-bit rate blocks, appends SHA-3
// padding on the final word and hands each block to the permutation.
module sha3_padder
  import sha3_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in,
  input  logic              in_ready,
  input  logic              is_last,
  input  logic [1:0]        byte_num,
  input  logic              f_ack,
  output logic              buffer_full,
  output logic [RATE_W-1:0] out,
  output logic              out_ready,
  output logic              out_last
);

  state_e            state;
  logic [4:0]        word_cnt;
  logic [4:0]        cnt_inc;
  logic              at_end;
  logic [WORD_W-1:0] pad_word;
  logic [WORD_W-1:0] last_word;
  logic [WORD_W-1:0] zero_word;

  sha3_pad_word u_pad_word (
    .in       (in),
    .byte_num (byte_num),
    .out      (pad_word)
  );

  // at_end marks the word about to land in slot 17; a final block gets
  // the closing 0x80 bit ORed into exactly that word.
  always_comb begin
    cnt_inc   = word_cnt + 5'd1;
    at_end    = (cnt_inc == LAST_CNT);
    last_word = at_end ? (pad_word | {24'h00_0000, PAD_END}) : pad_word;
    zero_word = at_end ? {24'h00_0000, PAD_END} : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACCEPT;
      word_cnt    <= '0;
      out         <= '0;
      out_ready   <= 1'b0;
      out_last    <= 1'b0;
      buffer_full <= 1'b0;
    end else begin
      unique case (state)
        ACCEPT: begin
          if (in_ready && !buffer_full) begin
            word_cnt <= cnt_inc;
            if (is_last) begin
              out         <= {out[RATE_W-WORD_W-1:0], last_word};
              buffer_full <= 1'b1;
              if (at_end) begin
                state     <= FULL;
                out_ready <= 1'b1;
                out_last  <= 1'b1;
              end else begin
                state <= PAD;
              end
            end else begin
              out <= {out[RATE_W-WORD_W-1:0], in};
              if (at_end) begin
                state       <= FULL;
                out_ready   <= 1'b1;
                out_last    <= 1'b0;
                buffer_full <= 1'b1;
              end
            end
          end
        end
        PAD: begin
          out      <= {out[RATE_W-WORD_W-1:0], zero_word};
          word_cnt <= cnt_inc;
          if (at_end) begin
            state     <= FULL;
            out_ready <= 1'b1;
            out_last  <= 1'b1;
          end
        end
        FULL: begin
          if (f_ack) begin
            state       <= ACCEPT;
            word_cnt    <= '0;
            out_ready   <= 1'b0;
            out_last    <= 1'b0;
            buffer_full <= 1'b0;
          end
        end
        default: begin
          state       <= ACCEPT;
          word_cnt    <= '0;
          out_ready   <= 1'b0;
          out_last    <= 1'b0;
          buffer_full <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_padder.sv
// Self-checking bench for sha3_padder: directed scenarios plus randomized
// messages compared against a word-list padding model.
module tb_sha3_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_w;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         f_ack;
  logic         buffer_full;
  logic [575:0] out_blk;
  logic         out_ready;
  logic         out_last;

  int n_cmp = 0;
  int n_err = 0;

  logic [575:0] exp_blk[$];
  bit           exp_last[$];

  sha3_padder dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in_w),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .f_ack       (f_ack),
    .buffer_full (buffer_full),
    .out         (out_blk),
    .out_ready   (out_ready),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  // Final word: keep the first bn bytes, put 0x01 right after them.
  function automatic logic [31:0] ref_pad(input logic [31:0] w, input int bn);
    logic [31:0] keep;
    keep = ~(32'hFFFF_FFFF >> (8 * bn));
    return (w & keep) | (32'h0100_0000 >> (8 * bn));
  endfunction

  function automatic logic [575:0] pack18(input logic [31:0] s[$], input int base);
    logic [575:0] b;
    b = '0;
    for (int k = 0; k < 18; k++) b = {b[543:0], s[base + k]};
    return b;
  endfunction

  task automatic model_msg(input logic [31:0] msg[$], input int bn);
    logic [31:0] s[$];
    int nb;
    s = msg;
    s[s.size() - 1] = ref_pad(s[s.size() - 1], bn);
    while (s.size() % 18 != 0) s.push_back(32'h0);
    s[s.size() - 1] = s[s.size() - 1] | 32'h0000_0080;
    nb = s.size() / 18;
    exp_blk.delete();
    exp_last.delete();
    for (int b = 0; b < nb; b++) begin
      exp_blk.push_back(pack18(s, b * 18));
      exp_last.push_back(b == nb - 1);
    end
  endtask

  task automatic drive(input logic [31:0] w, input logic last, input logic [1:0] bn);
    in_w     = w;
    is_last  = last;
    byte_num = bn;
    in_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic ack();
    f_ack = 1'b1;
    @(negedge clk);
    f_ack = 1'b0;
  endtask

  // lat counts the accept edge as 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_ready && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_ready = 1'b1;
    in_w     = 32'hDEAD_BEEF;
    is_last  = 1'b0;
    byte_num = 2'd0;
    f_ack    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_blk, out_ready, out_last, buffer_full} !== 579'h0) begin
      n_err++;
      $display("FAIL reset_state: out_ready=%b out_last=%b buffer_full=%b out_nonzero=%b, want all 0",
               out_ready, out_last, buffer_full, |out_blk);
    end
    reset    = 1'b0;
    in_ready = 1'b0;
    f_ack    = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_block();
    logic [31:0] s[$];
    for (int i = 1; i <= 18; i++) begin
      s.push_back(32'(i));
      if (i == 18) begin
        n_cmp++;
        if (out_ready !== 1'b0) begin
          n_err++;
          $display("FAIL full_early: out_ready=%b after 17 words, want 0", out_ready);
        end
      end
      drive(32'(i), 1'b0, 2'd0);
    end
    in_ready = 1'b0;
    n_cmp++;
    if (out_ready !== 1'b1 || buffer_full !== 1'b1) begin
      n_err++;
      $display("FAIL full_ready: out_ready=%b buffer_full=%b, want 1 1", out_ready, buffer_full);
    end
    n_cmp++;
    if (out_blk[575:544] !== 32'h1 || out_blk[31:0] !== 32'h12 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL full_words: w0=%h w17=%h last=%b, want 00000001 00000012 0",
               out_blk[575:544], out_blk[31:0], out_last);
    end
    n_cmp++;
    if (out_blk !== pack18(s, 0)) begin
      n_err++;
      $display("FAIL full_block: got %h want %h", out_blk, pack18(s, 0));
    end
    ack();
    n_cmp++;
    if (buffer_full !== 1'b0 || out_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ack: buffer_full=%b out_ready=%b, want 0 0", buffer_full, out_ready);
    end
  endtask

  task automatic test_first_last();
    int lat;
    logic [575:0] want;
    drive($urandom, 1'b1, 2'd0);
    in_ready = 1'b0;
    n_cmp++;
    if (buffer_full !== 1'b1 || out_ready !== 1'b0) begin
      n_err++;
      $display("FAIL pad_enter: buffer_full=%b out_ready=%b, want 1 0", buffer_full, out_ready);
    end
    wait_out(lat);
    n_cmp++;
    if (lat != 18) begin
      n_err++;
      $display("FAIL pad_latency: got %0d cycles, want 18", lat);
    end
    want = {32'h0100_0000, 512'h0, 32'h0000_0080};
    n_cmp++;
    if (out_blk !== want || out_last !== 1'b1) begin
      n_err++;
      $display("FAIL pad_block: last=%b got %h want %h", out_last, out_blk, want);
    end
    ack();
  endtask

  task automatic test_slot17_last();
    logic [31:0] s[$];
    for (int i = 0; i < 17; i++) begin
      s.push_back($urandom);
      drive(s[i], 1'b0, 2'd0);
    end
    s.push_back(32'hAABB_CCDD);
    drive(32'hAABB_CCDD, 1'b1, 2'd3);
    in_ready = 1'b0;
    model_msg(s, 3);
    n_cmp++;
    if (out_ready !== 1'b1 || out_last !== 1'b1 || out_blk[31:0] !== 32'hAABB_CC81) begin
      n_err++;
      $display("FAIL slot17_last: ready=%b last=%b w17=%h, want 1 1 aabbcc81",
               out_ready, out_last, out_blk[31:0]);
    end
    n_cmp++;
    if (out_blk !== exp_blk[0]) begin
      n_err++;
      $display("FAIL slot17_block: got %h want %h", out_blk, exp_blk[0]);
    end
    ack();
  endtask

  task automatic test_bn2();
    int lat;
    drive(32'h1234_5678, 1'b1, 2'd2);
    in_ready = 1'b0;
    wait_out(lat);
    n_cmp++;
    if (out_ready !== 1'b1 || lat != 18) begin
      n_err++;
      $display("FAIL bn2_latency: ready=%b lat=%0d, want 1 18", out_ready, lat);
    end
    n_cmp++;
    if (out_blk[575:544] !== 32'h1234_0100 || out_blk[31:0] !== 32'h80 || out_last !== 1'b1) begin
      n_err++;
      $display("FAIL bn2_words: w0=%h w17=%h last=%b, want 12340100 00000080 1",
               out_blk[575:544], out_blk[31:0], out_last);
    end
    ack();
  endtask

  task automatic test_hold();
    logic [31:0] s[$];
    logic [31:0] m[$];
    logic [31:0] a;
    logic [31:0] b;
    int lat;
    int bad;
    for (int i = 0; i < 18; i++) begin
      s.push_back($urandom);
      drive(s[i], 1'b0, 2'd0);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_w     = $urandom;
      in_ready = 1'b1;
      is_last  = 1'b0;
      @(negedge clk);
      if (buffer_full !== 1'b1 || out_ready !== 1'b1 || out_blk !== pack18(s, 0)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hold_stable: %0d of 10 cycles not held, want 0", bad);
    end
    a = $urandom;
    b = $urandom;
    in_w  = a;
    f_ack = 1'b1;
    @(negedge clk);
    f_ack = 1'b0;
    n_cmp++;
    if (buffer_full !== 1'b0 || out_ready !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: buffer_full=%b out_ready=%b, want 0 0", buffer_full, out_ready);
    end
    @(negedge clk);
    drive(b, 1'b1, 2'd0);
    in_ready = 1'b0;
    wait_out(lat);
    m.push_back(a);
    m.push_back(b);
    model_msg(m, 0);
    n_cmp++;
    if (out_ready !== 1'b1 || out_blk !== exp_blk[0] || out_last !== 1'b1) begin
      n_err++;
      $display("FAIL hold_next: ready=%b last=%b got %h want %h", out_ready, out_last, out_blk,
               exp_blk[0]);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    logic [31:0] s[$];
    int lat;
    int seen;
    for (int i = 0; i < 5; i++) drive($urandom, 1'b0, 2'd0);
    reset = 1'b1;
    f_ack = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    f_ack    = 1'b0;
    in_ready = 1'b0;
    n_cmp++;
    if ({out_blk, out_ready, out_last, buffer_full} !== 579'h0) begin
      n_err++;
      $display("FAIL reset_mid_block: ready=%b last=%b full=%b out_nonzero=%b, want all 0",
               out_ready, out_last, buffer_full, |out_blk);
    end
    drive($urandom, 1'b1, 2'd1);
    in_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({out_blk, out_ready, out_last, buffer_full} !== 579'h0) begin
      n_err++;
      $display("FAIL reset_mid_pad: ready=%b last=%b full=%b out_nonzero=%b, want all 0",
               out_ready, out_last, buffer_full, |out_blk);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_ready) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_no_emit: out_ready high %0d cycles after reset, want 0", seen);
    end
    for (int i = 0; i < 18; i++) begin
      s.push_back($urandom);
      drive(s[i], 1'b0, 2'd0);
    end
    in_ready = 1'b0;
    wait_out(lat);
    n_cmp++;
    if (out_ready !== 1'b1 || lat != 1 || out_last !== 1'b0 || out_blk !== pack18(s, 0)) begin
      n_err++;
      $display("FAIL reset_recover: ready=%b lat=%0d last=%b got %h want %h", out_ready, lat,
               out_last, out_blk, pack18(s, 0));
    end
    ack();
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [31:0] msg[$];
      int n;
      int bn;
      int idx;
      int cyc;
      int wait_ack;
      bit seen;
      n  = $urandom_range(1, 40);
      bn = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) msg.push_back($urandom);
      model_msg(msg, bn);
      idx      = 0;
      cyc      = 0;
      seen     = 0;
      wait_ack = 0;
      while ((idx < n || exp_blk.size() > 0) && cyc < 3000) begin
        f_ack    = 1'b0;
        in_ready = 1'b0;
        if (out_ready) begin
          if (exp_blk.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rand_extra_block: msg %0d unexpected out_ready", t);
            break;
          end
          if (!seen) begin
            n_cmp++;
            if (out_blk !== exp_blk[0] || out_last !== exp_last[0]) begin
              n_err++;
              $display("FAIL rand_block: msg %0d n=%0d bn=%0d last=%b/%b got %h want %h", t, n,
                       bn, out_last, exp_last[0], out_blk, exp_blk[0]);
            end
            seen     = 1;
            wait_ack = $urandom_range(0, 3);
          end
          if (wait_ack == 0) begin
            f_ack = 1'b1;
            void'(exp_blk.pop_front());
            void'(exp_last.pop_front());
            seen = 0;
          end else begin
            wait_ack--;
          end
        end
        if (idx < n && !buffer_full && $urandom_range(0, 3) != 0) begin
          in_w     = msg[idx];
          is_last  = (idx == n - 1);
          byte_num = 2'(bn);
          in_ready = 1'b1;
          idx++;
        end else begin
          in_w = $urandom;
        end
        @(negedge clk);
        cyc++;
      end
      f_ack    = 1'b0;
      in_ready = 1'b0;
      @(negedge clk);
      if (cyc >= 3000) begin
        n_cmp++;
        n_err++;
        $display("FAIL rand_timeout: msg %0d left %0d words %0d blocks", t, n - idx,
                 exp_blk.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_first_last();
    test_slot17_last();
    test_bn2();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
